// File: rtl/cond_flag_unit_pkg.sv
// Shared types for the NZCV flag unit: status word layout, ALU ops, ARM condition codes.
// Used by cond_eval and cond_flag_unit.
package cond_flag_unit_pkg;

  localparam int WORD = 32;

  localparam int FLAG_N_BIT = 3;
  localparam int FLAG_Z_BIT = 2;
  localparam int FLAG_C_BIT = 1;
  localparam int FLAG_V_BIT = 0;

  // Field order matches the write-mask bit positions above.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_register;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_ADC = 4'h1,
    ALU_SUB = 4'h2,
    ALU_SBC = 4'h3,
    ALU_AND = 4'h4,
    ALU_ORR = 4'h5,
    ALU_EOR = 4'h6,
    ALU_MOV = 4'h7
  } alu_control_signal;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_code_t;

  // Per-flag select between the committed value and the ALU update.
  function automatic status_register merge_flags(status_register committed,
                                                 status_register update,
                                                 logic [3:0]     mask);
    logic [3:0] c_v;
    logic [3:0] u_v;
    c_v = committed;
    u_v = update;
    return status_register'((c_v & ~mask) | (u_v & mask));
  endfunction

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Purely combinational ARM condition-code evaluator over an NZCV status word.
// NV (4'hF) never passes.
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  cond_code_t     cond_code_i,
  input  status_register flags_i,
  output logic           taken_o
);

  logic n_eq_v_s;

  assign n_eq_v_s = (flags_i.n == flags_i.v);

  always_comb begin
    taken_o = 1'b0;
    case (cond_code_i)
      COND_EQ: taken_o = flags_i.z;
      COND_NE: taken_o = ~flags_i.z;
      COND_CS: taken_o = flags_i.c;
      COND_CC: taken_o = ~flags_i.c;
      COND_MI: taken_o = flags_i.n;
      COND_PL: taken_o = ~flags_i.n;
      COND_VS: taken_o = flags_i.v;
      COND_VC: taken_o = ~flags_i.v;
      COND_HI: taken_o = flags_i.c & ~flags_i.z;
      COND_LS: taken_o = ~flags_i.c | flags_i.z;
      COND_GE: taken_o = n_eq_v_s;
      COND_LT: taken_o = ~n_eq_v_s;
      COND_GT: taken_o = ~flags_i.z & n_eq_v_s;
      COND_LE: taken_o = flags_i.z | ~n_eq_v_s;
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register, exception shadow copy and registered branch-condition responder.
// Define COND_FLAG_BYPASS_EN to evaluate conditions on same-cycle ALU flags instead of stalling.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flag_wr_en_i,
  input  logic [3:0]     flag_wr_mask_i,
  input  status_register status_reg_i,
  input  logic           cond_req_valid_i,
  input  logic [3:0]     cond_code_i,
  input  logic           flush_i,
  input  logic           snapshot_i,
  input  logic           restore_i,
  output status_register flags_o,
  output logic           carry_flag_o,
  output logic           cond_stall_o,
  output logic           cond_resp_valid_o,
  output logic           cond_taken_o
);

  status_register flags_q, flags_d;
  status_register shadow_q, shadow_d;
  logic           resp_valid_q, resp_valid_d;
  logic           taken_q, taken_d;

  status_register eff_s;
  status_register eval_flags_s;
  logic           stall_s;
  logic           accept_s;
  logic           eval_taken_s;

  always_comb begin
    if (flag_wr_en_i) begin
      eff_s = merge_flags(flags_q, status_reg_i, flag_wr_mask_i);
    end else begin
      eff_s = flags_q;
    end
  end

`ifdef COND_FLAG_BYPASS_EN
  assign eval_flags_s = eff_s;
  assign stall_s      = 1'b0;
`else
  // Without the bypass, a branch colliding with a flag write waits one cycle for the commit.
  assign eval_flags_s = flags_q;
  assign stall_s      = cond_req_valid_i & flag_wr_en_i & ~rst_i;
`endif

  assign accept_s = cond_req_valid_i & ~stall_s & ~rst_i;

  cond_eval u_cond_eval (
    .cond_code_i (cond_code_t'(cond_code_i)),
    .flags_i     (eval_flags_s),
    .taken_o     (eval_taken_s)
  );

  // Restore takes priority over the ALU write; snapshot always captures the pre-restore eff.
  always_comb begin
    if (restore_i) begin
      flags_d = shadow_q;
    end else begin
      flags_d = eff_s;
    end
    if (snapshot_i) begin
      shadow_d = eff_s;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Flush only kills the response; flag and shadow updates above still happen.
  always_comb begin
    if (accept_s && !flush_i) begin
      resp_valid_d = 1'b1;
      taken_d      = eval_taken_s;
    end else begin
      resp_valid_d = 1'b0;
      taken_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q      <= status_register'(4'b0000);
      shadow_q     <= status_register'(4'b0000);
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      shadow_q     <= shadow_d;
      resp_valid_q <= resp_valid_d;
      taken_q      <= taken_d;
    end
  end

  assign flags_o           = flags_q;
  assign carry_flag_o      = flags_q.c;
  assign cond_stall_o      = stall_s;
  assign cond_resp_valid_o = resp_valid_q;
  assign cond_taken_o      = taken_q;

endmodule
